// File: rtl/irq_controller_pkg.sv
// Shared constants and types for the MMIO interrupt controller.
package irq_controller_pkg;

    localparam int ID_W            = 5;
    localparam int CLAIM_VALID_BIT = 31;

    // Register offsets, decoded from mmio_addr[4:0].
    localparam logic [4:0] ADDR_PEND  = 5'h00;
    localparam logic [4:0] ADDR_EN    = 5'h04;
    localparam logic [4:0] ADDR_TRIG  = 5'h08;
    localparam logic [4:0] ADDR_CLAIM = 5'h0C;
    localparam logic [4:0] ADDR_DONE  = 5'h10;
    localparam logic [4:0] ADDR_RAW   = 5'h14;

    // Controller state: free to raise cpu_irq, or one interrupt in service.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

endpackage

// File: rtl/irq_controller_prio_enc.sv
// Find-first-set priority encoder: the lowest set index wins.
module irq_controller_prio_enc
    import irq_controller_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]    req,
    output logic            any,
    output logic [ID_W-1:0] id
);

    // Scan from the top down so the lowest set index is the last assignment.
    always_comb begin
        any = |req;
        id  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// MMIO interrupt controller: per-source capture, mask, lowest-index
// priority and a claim/complete flow with one interrupt in service.
//
// Handshake: mmio_ready mirrors mmio_valid, so every access completes on the
// clk edge where mmio_valid=1; read data appears in mmio_rdata after that
// edge and holds until the next read.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] SYNC_MASK = 32'h0000_00FE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mmio_valid,
    input  logic               mmio_write,
    input  logic [31:0]        mmio_addr,
    input  logic [31:0]        mmio_wdata,
    input  logic [3:0]         mmio_wstrb,
    output logic [31:0]        mmio_rdata,
    output logic               mmio_ready,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               cpu_irq,
    output logic [ID_W-1:0]    cpu_irq_id,
    output state_t             dbg_state
);

    localparam int PAD = 32 - NUM_SRC;

    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] en_q, en_d;
    logic [NUM_SRC-1:0] trig_q, trig_d;
    logic [ID_W-1:0]    svc_id_q, svc_id_d;
    logic               cpu_irq_q, cpu_irq_d;
    logic [ID_W-1:0]    cpu_irq_id_q, cpu_irq_id_d;
    logic [31:0]        rdata_q, rdata_d;
    state_t             state_q, state_d;

    logic [4:0]         addr;
    logic               rd_en, wr_en;
    logic               claim_take, done_hit;
    logic [NUM_SRC-1:0] w1c, claim_clr, edge_ev;
    logic               win_any;
    logic [ID_W-1:0]    win_id;
    logic               unused_bits;

    assign addr        = mmio_addr[4:0];
    assign mmio_ready  = mmio_valid;
    assign mmio_rdata  = rdata_q;
    assign cpu_irq     = cpu_irq_q;
    assign cpu_irq_id  = cpu_irq_id_q;
    assign dbg_state   = state_q;
    assign unused_bits = ^{mmio_addr, mmio_wdata, mmio_wstrb};

    // Asynchronous pins pass two flops; same-clock sources go straight through.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        if (SYNC_MASK[i]) begin : g_sync
            logic meta_q, sync_q;
            // Two-flop synchroniser for source i.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                end else begin
                    meta_q <= irq_src[i];
                    sync_q <= meta_q;
                end
            end
            assign src_s[i] = sync_q;
        end else begin : g_direct
            assign src_s[i] = irq_src[i];
        end
    end

    irq_controller_prio_enc #(.N(NUM_SRC)) u_prio (
        .req (pend_q & en_q),
        .any (win_any),
        .id  (win_id)
    );

    // Bus decode: access strobes and the claim/complete qualifiers.
    always_comb begin
        rd_en      = mmio_valid && !mmio_write;
        wr_en      = mmio_valid && mmio_write && mmio_wstrb[0];
        claim_take = rd_en && (addr == ADDR_CLAIM) && (state_q == ST_IDLE) && win_any;
        done_hit   = wr_en && (addr == ADDR_DONE) && (state_q == ST_SERVICE) &&
                     (mmio_wdata[ID_W-1:0] == svc_id_q);
        w1c        = (wr_en && addr == ADDR_PEND) ? mmio_wdata[NUM_SRC-1:0] : '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_clr[i] = claim_take && (win_id == ID_W'(i));
        end
    end

    // Capture: edge sources latch until cleared (a new edge beats a clear),
    // level sources follow the synchronised input every cycle.
    always_comb begin
        edge_ev = src_s & ~prev_q;
        pend_d  = pend_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (trig_q[i]) begin
                pend_d[i] = (pend_q[i] & ~w1c[i] & ~claim_clr[i]) | edge_ev[i];
            end else begin
                pend_d[i] = src_s[i];
            end
        end
        en_d   = (wr_en && addr == ADDR_EN)   ? mmio_wdata[NUM_SRC-1:0] : en_q;
        trig_d = (wr_en && addr == ADDR_TRIG) ? mmio_wdata[NUM_SRC-1:0] : trig_q;
    end

    // Claim/complete state machine and the CPU interrupt outputs.
    always_comb begin
        state_d      = state_q;
        svc_id_d     = svc_id_q;
        cpu_irq_d    = 1'b0;
        cpu_irq_id_d = cpu_irq_id_q;
        case (state_q)
            ST_IDLE: begin
                cpu_irq_d    = win_any;
                cpu_irq_id_d = win_id;
                if (claim_take) begin
                    // Drop the line immediately so the CPU does not see a stale request.
                    cpu_irq_d = 1'b0;
                    svc_id_d  = win_id;
                    state_d   = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (done_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read mux: returns register state from before this edge's updates.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (addr)
                ADDR_PEND:  rdata_d = {{PAD{1'b0}}, pend_q};
                ADDR_EN:    rdata_d = {{PAD{1'b0}}, en_q};
                ADDR_TRIG:  rdata_d = {{PAD{1'b0}}, trig_q};
                ADDR_CLAIM: rdata_d = claim_take ? {1'b1, 26'b0, win_id} : 32'h0;
                ADDR_RAW:   rdata_d = {{PAD{1'b0}}, src_s};
                default:    rdata_d = 32'h0;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q       <= '0;
            pend_q       <= '0;
            en_q         <= '0;
            trig_q       <= '0;
            svc_id_q     <= '0;
            cpu_irq_q    <= 1'b0;
            cpu_irq_id_q <= '0;
            rdata_q      <= '0;
            state_q      <= ST_IDLE;
        end else begin
            prev_q       <= src_s;
            pend_q       <= pend_d;
            en_q         <= en_d;
            trig_q       <= trig_d;
            svc_id_q     <= svc_id_d;
            cpu_irq_q    <= cpu_irq_d;
            cpu_irq_id_q <= cpu_irq_id_d;
            rdata_q      <= rdata_d;
            state_q      <= state_d;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller.
module tb_irq_controller;
    import irq_controller_pkg::*;

    localparam logic [31:0] A_PEND  = 32'h8000_0040;
    localparam logic [31:0] A_EN    = 32'h8000_0044;
    localparam logic [31:0] A_TRIG  = 32'h8000_0048;
    localparam logic [31:0] A_CLAIM = 32'h8000_004C;
    localparam logic [31:0] A_DONE  = 32'h8000_0050;

    logic        clk = 1'b0;
    logic        reset;
    logic        mmio_valid, mmio_write;
    logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;
    logic [3:0]  mmio_wstrb;
    logic        mmio_ready;
    logic [7:0]  irq_src;
    logic        cpu_irq;
    logic [4:0]  cpu_irq_id;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    irq_controller #(.NUM_SRC(8), .SYNC_MASK(32'h0000_00FE)) dut (
        .clk        (clk),
        .reset      (reset),
        .mmio_valid (mmio_valid),
        .mmio_write (mmio_write),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_wstrb (mmio_wstrb),
        .mmio_rdata (mmio_rdata),
        .mmio_ready (mmio_ready),
        .irq_src    (irq_src),
        .cpu_irq    (cpu_irq),
        .cpu_irq_id (cpu_irq_id),
        .dbg_state  (dbg_state)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        mmio_valid = 1'b1; mmio_write = 1'b1; mmio_addr = a; mmio_wdata = d; mmio_wstrb = 4'hF;
        tick();
        mmio_valid = 1'b0; mmio_write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        mmio_valid = 1'b1; mmio_write = 1'b0; mmio_addr = a;
        tick();
        d = mmio_rdata;
        mmio_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mmio_valid = 1'b0; mmio_write = 1'b0;
        mmio_addr = '0; mmio_wdata = '0; mmio_wstrb = '0; irq_src = '0;
        tick(3);
        check("rst_cpu_irq", 32'(cpu_irq), 32'h0);
        check("rst_irq_id", 32'(cpu_irq_id), 32'h0);
        check("rst_rdata", mmio_rdata, 32'h0);
        reset = 1'b0;
        bus_read(A_PEND, rd); check("rst_pend", rd, 32'h0);
        bus_read(A_EN, rd);   check("rst_en", rd, 32'h0);
        mmio_valid = 1'b1; #1;
        check("ready_follows_valid", 32'(mmio_ready), 32'h1);
        mmio_valid = 1'b0; #1;
        check("ready_low", 32'(mmio_ready), 32'h0);

        // 1: timer pulse -> PEND next edge, cpu_irq one edge later.
        bus_write(A_EN, 32'h01);
        bus_write(A_TRIG, 32'h01);
        irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
        check("t1_irq_not_yet", 32'(cpu_irq), 32'h0);
        bus_read(A_PEND, rd); check("t1_pend", rd, 32'h01);
        check("t1_cpu_irq", 32'(cpu_irq), 32'h1);
        check("t1_irq_id", 32'(cpu_irq_id), 32'h0);
        bus_read(A_CLAIM, rd); check("t1_claim", rd, 32'h8000_0000);
        check("t1_irq_drop", 32'(cpu_irq), 32'h0);
        check("t1_service", 32'(dbg_state), 32'(ST_SERVICE));
        bus_read(A_PEND, rd); check("t1_pend_cleared", rd, 32'h0);
        bus_write(A_DONE, 32'h0);
        check("t1_idle", 32'(dbg_state), 32'(ST_IDLE));

        // 2: synchronised edge sources 3 and 5 together.
        bus_write(A_TRIG, 32'h29);
        bus_write(A_EN, 32'h28);
        irq_src[3] = 1'b1; irq_src[5] = 1'b1; tick();
        irq_src[3] = 1'b0; irq_src[5] = 1'b0; tick(5);
        check("t2_cpu_irq", 32'(cpu_irq), 32'h1);
        check("t2_irq_id3", 32'(cpu_irq_id), 32'h3);
        bus_read(A_CLAIM, rd); check("t2_claim3", rd, 32'h8000_0003);
        bus_write(A_DONE, 32'h3);
        tick();
        check("t2_reassert", 32'(cpu_irq), 32'h1);
        check("t2_irq_id5", 32'(cpu_irq_id), 32'h5);
        bus_read(A_CLAIM, rd); check("t2_claim5", rd, 32'h8000_0005);
        bus_write(A_DONE, 32'h5);

        // 3: level source 2 survives claim, clears after the sync delay.
        bus_write(A_EN, 32'h04);
        irq_src[2] = 1'b1; tick(4);
        check("t3_irq_id2", 32'(cpu_irq_id), 32'h2);
        bus_read(A_CLAIM, rd); check("t3_claim2", rd, 32'h8000_0002);
        bus_read(A_PEND, rd);  check("t3_pend_level", rd, 32'h04);
        bus_write(A_DONE, 32'h2);
        irq_src[2] = 1'b0; tick(3);
        bus_read(A_PEND, rd);  check("t3_pend_drop", rd, 32'h0);
        tick();
        check("t3_irq_low", 32'(cpu_irq), 32'h0);

        // 4: W1C on the same edge as a new timer edge: set wins.
        bus_write(A_EN, 32'h00);
        irq_src[0] = 1'b1;
        bus_write(A_PEND, 32'h01);
        irq_src[0] = 1'b0;
        bus_read(A_PEND, rd); check("t4_set_wins", rd, 32'h01);
        bus_write(A_PEND, 32'h01);
        bus_read(A_PEND, rd); check("t4_w1c", rd, 32'h0);

        // 5: claims in service, wrong DONE, empty claim.
        bus_write(A_EN, 32'h01);
        irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0; tick();
        bus_read(A_CLAIM, rd); check("t5_claim0", rd, 32'h8000_0000);
        bus_read(A_CLAIM, rd); check("t5_claim_in_svc", rd, 32'h0);
        bus_write(A_DONE, 32'h3);
        check("t5_wrong_done", 32'(dbg_state), 32'(ST_SERVICE));
        bus_write(A_DONE, 32'h0);
        check("t5_done", 32'(dbg_state), 32'(ST_IDLE));
        bus_read(A_CLAIM, rd); check("t5_claim_empty", rd, 32'h0);
        check("t5_still_idle", 32'(dbg_state), 32'(ST_IDLE));

        // 6: reset mid-service with the timer source held high.
        irq_src[0] = 1'b1; tick(2);
        bus_read(A_CLAIM, rd); check("t6_claim0", rd, 32'h8000_0000);
        reset = 1'b1; #1;
        check("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("t6_rst_irq", 32'(cpu_irq), 32'h0);
        check("t6_rst_rdata", mmio_rdata, 32'h0);
        tick(2);
        reset = 1'b0;
        bus_read(A_PEND, rd); check("t6_pend_pre", rd, 32'h0);
        bus_read(A_PEND, rd); check("t6_pend_set", rd, 32'h01);
        bus_read(A_EN, rd);   check("t6_en_clr", rd, 32'h0);
        irq_src = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
